// File: rtl/calc_pkg.sv
// Shared encodings for the calculator engine: modes, per-mode op codes and FSM states.
package calc_pkg;

    localparam logic [1:0] MODE_ARITH = 2'd0;
    localparam logic [1:0] MODE_LOGIC = 2'd1;
    localparam logic [1:0] MODE_CMP   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    localparam logic [1:0] OP_EQ  = 2'd0;
    localparam logic [1:0] OP_GT  = 2'd1;
    localparam logic [1:0] OP_LT  = 2'd2;
    localparam logic [1:0] OP_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic logic is_iterative(input logic [1:0] mode, input logic [1:0] op);
        return (mode == MODE_ARITH) && ((op == OP_MUL) || (op == OP_DIV));
    endfunction

endpackage

// File: rtl/calc_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one W-cycle counter.
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic           div_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] result_o
);

    localparam int CW = $clog2(W + 1);

    // hi holds the running partial product (mul) or partial remainder (div);
    // lo holds the multiplier being consumed (mul) or the quotient being built (div).
    logic [W:0]    hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic          busy_q, busy_d;

    logic [W:0] sum_s;
    logic [W:0] shift_s;
    logic [W:0] trial_s;

    // Next-state: load on start, then one multiply or divide step per cycle.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        busy_d  = busy_q;
        sum_s   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        shift_s = {hi_q[W-1:0], lo_q[W-1]};
        trial_s = shift_s - {1'b0, opnd_q};
        if (start_i) begin
            hi_d   = {(W+1){1'b0}};
            lo_d   = div_i ? a_i : b_i;
            opnd_d = div_i ? b_i : a_i;
            cnt_d  = CW'(W);
            div_d  = div_i;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (div_q) begin
                if (!trial_s[W]) begin
                    hi_d = trial_s;
                    lo_d = {lo_q[W-2:0], 1'b1};
                end else begin
                    hi_d = shift_s;
                    lo_d = {lo_q[W-2:0], 1'b0};
                end
            end else begin
                hi_d = {1'b0, sum_s[W:1]};
                lo_d = {sum_s[0], lo_q[W-1:1]};
            end
            cnt_d  = cnt_q - CW'(1);
            busy_d = (cnt_q != CW'(1));
        end else begin
            busy_d = 1'b0;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hi_q   <= {(W+1){1'b0}};
            lo_q   <= {W{1'b0}};
            opnd_q <= {W{1'b0}};
            cnt_q  <= {CW{1'b0}};
            div_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            busy_q <= busy_d;
        end
    end

    assign done_o   = busy_q && (cnt_q == CW'(1));
    assign result_o = {hi_q[W-1:0], lo_q};

endmodule

// File: rtl/calc_engine.sv
// W-bit arithmetic/logical/compare engine with push-button mode select and a
// START/BUSY/DONE handshake; results and flags hold until the next completion.
module calc_engine
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [1:0]     KEY_N,
    input  logic           START,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [1:0]     OP,
    output logic [1:0]     MODE,
    output logic [2*W-1:0] RESULT,
    output logic           OVF,
    output logic           DIV0,
    output logic           BUSY,
    output logic           DONE
);

    logic [1:0] key_s1_q, key_s2_q, key_s3_q;
    logic [1:0] press_s;
    logic [1:0] mode_q, mode_d;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [1:0]     op_q, cmode_q;
    logic [2*W-1:0] result_q;
    logic           ovf_q, div0_q, done_q, busy_q;

    logic           cap_s, load_s, md_start_s, md_done_s;
    logic [2*W-1:0] md_result_s;
    logic [2*W-1:0] res_s;
    logic           ovf_s, div0_s;
    logic [W:0]     sum_s;
    logic [W-1:0]   diff_s;

    // Falling edge of a synchronized key; both keys together cancel out.
    assign press_s = key_s3_q & ~key_s2_q;

    // Mode step from key presses.
    always_comb begin
        mode_d = mode_q;
        case (press_s)
            2'b01:   mode_d = mode_q + 2'd1;
            2'b10:   mode_d = mode_q - 2'd1;
            default: mode_d = mode_q;
        endcase
    end

    // Key synchronizer, edge register and mode register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            key_s1_q <= 2'b11;
            key_s2_q <= 2'b11;
            key_s3_q <= 2'b11;
            mode_q   <= MODE_ARITH;
        end else begin
            key_s1_q <= KEY_N;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            mode_q   <= mode_d;
        end
    end

    // Control FSM; a divide by zero skips iteration and finishes directly.
    always_comb begin
        state_d    = state_q;
        cap_s      = 1'b0;
        load_s     = 1'b0;
        md_start_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    cap_s = 1'b1;
                    if (is_iterative(mode_q, OP) && !((OP == OP_DIV) && (B == {W{1'b0}}))) begin
                        md_start_s = 1'b1;
                        state_d    = RUN;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (md_done_s) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
            end
            FINISH: begin
                load_s  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and flags from the captured operands.
    always_comb begin
        res_s  = {(2*W){1'b0}};
        ovf_s  = 1'b0;
        div0_s = 1'b0;
        sum_s  = {1'b0, a_q} + {1'b0, b_q};
        diff_s = a_q - b_q;
        case (cmode_q)
            MODE_ARITH: begin
                case (op_q)
                    OP_ADD: begin
                        res_s = {{(W-1){1'b0}}, sum_s};
                        ovf_s = sum_s[W];
                    end
                    OP_SUB: begin
                        res_s = {{W{diff_s[W-1]}}, diff_s};
                        ovf_s = (a_q < b_q);
                    end
                    OP_MUL: res_s = md_result_s;
                    OP_DIV: begin
                        if (b_q == {W{1'b0}}) begin
                            res_s  = {(2*W){1'b1}};
                            div0_s = 1'b1;
                        end else begin
                            res_s = md_result_s;
                        end
                    end
                    default: res_s = {(2*W){1'b0}};
                endcase
            end
            MODE_LOGIC: begin
                case (op_q)
                    OP_AND:  res_s = {{W{1'b0}}, a_q & b_q};
                    OP_OR:   res_s = {{W{1'b0}}, a_q | b_q};
                    OP_XOR:  res_s = {{W{1'b0}}, a_q ^ b_q};
                    OP_NOT:  res_s = {{W{1'b0}}, ~a_q};
                    default: res_s = {(2*W){1'b0}};
                endcase
            end
            MODE_CMP: begin
                case (op_q)
                    OP_EQ:   res_s = {{(2*W-1){1'b0}}, (a_q == b_q)};
                    OP_GT:   res_s = {{(2*W-1){1'b0}}, (a_q > b_q)};
                    OP_LT:   res_s = {{(2*W-1){1'b0}}, (a_q < b_q)};
                    OP_MAX:  res_s = {{W{1'b0}}, (a_q > b_q) ? a_q : b_q};
                    default: res_s = {(2*W){1'b0}};
                endcase
            end
            default: res_s = {(2*W){1'b0}};
        endcase
    end

    // State, operand capture and held output registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            op_q     <= 2'd0;
            cmode_q  <= MODE_ARITH;
            result_q <= {(2*W){1'b0}};
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= load_s;
            if (cap_s) begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= OP;
                cmode_q <= mode_q;
            end
            if (load_s) begin
                result_q <= res_s;
                ovf_q    <= ovf_s;
                div0_q   <= div0_s;
            end
        end
    end

    calc_muldiv #(.W(W)) u_muldiv (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .start_i  (md_start_s),
        .div_i    (OP == OP_DIV),
        .a_i      (A),
        .b_i      (B),
        .done_o   (md_done_s),
        .result_o (md_result_s)
    );

    assign MODE   = mode_q;
    assign RESULT = result_q;
    assign OVF    = ovf_q;
    assign DIV0   = div0_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed, table-driven bench for calc_engine (W=4 main instance, W=8 reset instance).
module tb_calc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n, start4, ovf4, div04, busy4, done4;
    logic [1:0] key4_n, op4, mode4;
    logic [3:0] a4, b4;
    logic [7:0] res4;

    logic        rst8_n, start8, ovf8, div08, busy8, done8;
    logic [1:0]  key8_n, op8, mode8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    calc_engine #(.W(4)) dut4 (
        .CLK(clk), .RST_N(rst4_n), .KEY_N(key4_n), .START(start4), .A(a4), .B(b4),
        .OP(op4), .MODE(mode4), .RESULT(res4), .OVF(ovf4), .DIV0(div04),
        .BUSY(busy4), .DONE(done4)
    );

    calc_engine #(.W(8)) dut8 (
        .CLK(clk), .RST_N(rst8_n), .KEY_N(key8_n), .START(start8), .A(a8), .B(b8),
        .OP(op8), .MODE(mode8), .RESULT(res8), .OVF(ovf8), .DIV0(div08),
        .BUSY(busy8), .DONE(done8)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       ovf;
        logic       div0;
        int         lat;
        bit         stray;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_mode = 0;
    int   done4_cnt = 0;
    int   done8_cnt = 0;

    always @(negedge clk) begin
        if (done4 === 1'b1) done4_cnt <= done4_cnt + 1;
        if (done8 === 1'b1) done8_cnt <= done8_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] mode, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] res, input logic ovf,
                           input logic div0, input int lat, input bit stray, input string name);
        vec_t v;
        v.mode = mode; v.op = op; v.a = a; v.b = b; v.res = res;
        v.ovf = ovf; v.div0 = div0; v.lat = lat; v.stray = stray; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic press(input logic [1:0] keys);
        @(negedge clk); key4_n = ~keys;
        repeat (5) @(posedge clk);
        @(negedge clk); key4_n = 2'b11;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic goto_mode(input logic [1:0] m);
        while (exp_mode != int'(m)) begin
            press(2'b01);
            exp_mode = (exp_mode + 1) % 4;
            check("mode_goto", {30'd0, mode4}, exp_mode);
        end
    endtask

    task automatic key_step(input logic [1:0] keys, input int nxt, input string nm);
        @(negedge clk); key4_n = ~keys;
        @(posedge clk); #1; check({nm, "_c1"}, {30'd0, mode4}, exp_mode);
        @(posedge clk); #1; check({nm, "_c2"}, {30'd0, mode4}, exp_mode);
        @(posedge clk); #1; exp_mode = nxt; check({nm, "_c3"}, {30'd0, mode4}, exp_mode);
        repeat (3) @(posedge clk);
        #1; check({nm, "_held"}, {30'd0, mode4}, exp_mode);
        @(negedge clk); key4_n = 2'b11;
        repeat (4) @(posedge clk);
        #1; check({nm, "_rel"}, {30'd0, mode4}, exp_mode);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int bc;
        goto_mode(v.mode);
        @(negedge clk); a4 = v.a; b4 = v.b; op4 = v.op; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        bc  = busy4 ? 1 : 0;
        while (done4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            if (v.stray && lat < 3) begin
                start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; op4 = 2'd0;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy4) bc++;
        end
        start4 = 1'b0;
        check({v.name, "_res"},  {24'd0, res4}, {24'd0, v.res});
        check({v.name, "_ovf"},  {31'd0, ovf4}, {31'd0, v.ovf});
        check({v.name, "_div0"}, {31'd0, div04}, {31'd0, v.div0});
        check({v.name, "_lat"},  lat, v.lat);
        check({v.name, "_busy"}, bc, v.lat);
        @(posedge clk); #1;
        check({v.name, "_pulse"}, {31'd0, done4}, 32'd0);
        check({v.name, "_idle"},  {31'd0, busy4}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dsnap;
        rst4_n = 1'b0; key4_n = 2'b11; start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; op4 = 2'd0;
        rst8_n = 1'b0; key8_n = 2'b11; start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; op8 = 2'd0;

        add_vec(2'd0, 2'd0, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1, 1'b0, "add_carry");
        add_vec(2'd0, 2'd0, 4'h3, 4'h4, 8'h07, 1'b0, 1'b0, 1, 1'b0, "add_plain");
        add_vec(2'd0, 2'd1, 4'h3, 4'h5, 8'hFE, 1'b1, 1'b0, 1, 1'b0, "sub_borrow");
        add_vec(2'd0, 2'd1, 4'h9, 4'h2, 8'h07, 1'b0, 1'b0, 1, 1'b0, "sub_plain");
        add_vec(2'd0, 2'd1, 4'h2, 4'h9, 8'hF9, 1'b1, 1'b0, 1, 1'b0, "sub_neg");
        add_vec(2'd0, 2'd2, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 5, 1'b1, "mul_ff");
        add_vec(2'd0, 2'd2, 4'h3, 4'h5, 8'h0F, 1'b0, 1'b0, 5, 1'b0, "mul_35");
        add_vec(2'd0, 2'd3, 4'hD, 4'h3, 8'h14, 1'b0, 1'b0, 5, 1'b0, "div_d3");
        add_vec(2'd0, 2'd3, 4'h7, 4'h0, 8'hFF, 1'b0, 1'b1, 1, 1'b0, "div_zero");
        add_vec(2'd0, 2'd3, 4'hF, 4'h1, 8'h0F, 1'b0, 1'b0, 5, 1'b0, "div_f1");
        add_vec(2'd0, 2'd3, 4'h2, 4'h7, 8'h20, 1'b0, 1'b0, 5, 1'b0, "div_27");
        add_vec(2'd1, 2'd0, 4'hC, 4'hA, 8'h08, 1'b0, 1'b0, 1, 1'b0, "and");
        add_vec(2'd1, 2'd1, 4'hC, 4'hA, 8'h0E, 1'b0, 1'b0, 1, 1'b0, "or");
        add_vec(2'd1, 2'd2, 4'hC, 4'hA, 8'h06, 1'b0, 1'b0, 1, 1'b0, "xor");
        add_vec(2'd1, 2'd3, 4'hC, 4'hA, 8'h03, 1'b0, 1'b0, 1, 1'b0, "not");
        add_vec(2'd2, 2'd0, 4'h5, 4'h5, 8'h01, 1'b0, 1'b0, 1, 1'b0, "eq");
        add_vec(2'd2, 2'd1, 4'h9, 4'h6, 8'h01, 1'b0, 1'b0, 1, 1'b0, "gt");
        add_vec(2'd2, 2'd2, 4'h9, 4'h6, 8'h00, 1'b0, 1'b0, 1, 1'b0, "lt");
        add_vec(2'd2, 2'd3, 4'h6, 4'h9, 8'h09, 1'b0, 1'b0, 1, 1'b0, "max");
        add_vec(2'd3, 2'd0, 4'hF, 4'hF, 8'h00, 1'b0, 1'b0, 1, 1'b0, "rsvd");

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode",   {30'd0, mode4}, 32'd0);
        check("rst_result", {24'd0, res4},  32'd0);
        check("rst_flags",  {30'd0, ovf4, div04}, 32'd0);
        check("rst_busy",   {30'd0, busy4, done4}, 32'd0);
        @(negedge clk); rst4_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;
        check("rel_mode",  {30'd0, mode4}, 32'd0);
        check("rel_busy",  {30'd0, busy4, done4}, 32'd0);

        // Key path: 0->1->2->1->0->3, then both keys together
        key_step(2'b01, 1, "key_up1");
        key_step(2'b01, 2, "key_up2");
        key_step(2'b10, 1, "key_dn1");
        key_step(2'b10, 0, "key_dn2");
        key_step(2'b10, 3, "key_dn3");
        key_step(2'b11, 3, "key_both");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Results hold while inputs and mode move
        goto_mode(2'd2);
        run_vec(vecs[18]);
        dsnap = done4_cnt;
        @(negedge clk); a4 = 4'h1; b4 = 4'hE; op4 = 2'd1;
        goto_mode(2'd3);
        goto_mode(2'd0);
        repeat (4) @(posedge clk);
        #1;
        check("hold_res",   {24'd0, res4}, 32'h09);
        check("hold_flags", {30'd0, ovf4, div04}, 32'd0);
        check("hold_nodone", done4_cnt, dsnap);

        // W=8: prior result, then reset mid-multiply
        @(negedge clk); a8 = 8'h50; b8 = 8'h0A; op8 = 2'd0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        check("w8_add_done", {31'd0, done8}, 32'd1);
        check("w8_add_res",  {16'd0, res8}, 32'h005A);
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; op8 = 2'd2; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        check("w8_busy", {31'd0, busy8}, 32'd1);
        @(negedge clk); key8_n = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("w8_mode_busy", {30'd0, mode8}, 32'd1);
        check("w8_still_busy", {31'd0, busy8}, 32'd1);
        dsnap = done8_cnt;
        @(negedge clk); rst8_n = 1'b0; key8_n = 2'b11;
        @(posedge clk); #1;
        check("w8_rst_res",  {16'd0, res8}, 32'd0);
        check("w8_rst_busy", {31'd0, busy8}, 32'd0);
        check("w8_rst_mode", {30'd0, mode8}, 32'd0);
        check("w8_rst_done", {31'd0, done8}, 32'd0);
        @(negedge clk); rst8_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("w8_no_done", done8_cnt, dsnap);
        check("w8_idle_res", {16'd0, res8}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_engine.md
# calc_engine

Parametrised, clocked successor to the board-level switch calculator: a W-bit arithmetic/logical/comparison engine with a registered mode selector driven by push-button edges, a START/BUSY/DONE handshake, and iterative multiply and divide. It sits between the switch/key inputs and the seven-segment/LED display muxes. Results and flags are held stable until the next accepted operation, so the displays no longer follow the switches combinationally.

## Interface
- W, 4: operand width; legal values 2..16.
- CLK  in  1  system clock; 50 MHz on DE10-Lite.
- RST_N  in  1  reset, synchronous, active-low.
- KEY_N  in  2  raw push-buttons, active-low, asynchronous.
  - [0] is mode up; [1] is mode down.
- START  in  1  single-cycle request to run the operation on A, B and OP.
- A  in  W  operand X.
- B  in  W  operand Y.
- OP  in  2  operation select within the current mode.
- MODE  out  2  current mode: 0 arith, 1 logical, 2 compare, 3 reserved.
- RESULT  out  2W  result register.
- OVF  out  1  carry/borrow flag.
- DIV0  out  1  divide-by-zero flag.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse when RESULT and the flags become valid.

## Operation
- Key path:
  - KEY_N passes through a 2-flop synchronizer, then falling-edge detect.
  - A KEY_N[0] press increments MODE, wrapping 3 to 0.
  - A KEY_N[1] press decrements MODE, wrapping 0 to 3.
  - Both pressed in the same cycle: MODE unchanged.
  - MODE updates at any time, including while BUSY.
- START is accepted only in IDLE. In the accept cycle, A, B, OP and MODE are captured; START while BUSY is ignored.
- Mode 0, arithmetic:
  - OP 0, add: RESULT = zero-extended W+1-bit sum; OVF = carry out.
  - OP 1, sub: RESULT = W-bit A−B, sign-extended to 2W; OVF = borrow (A<B).
  - OP 2, mul: unsigned shift-add, one partial product per cycle; RESULT = 2W product; OVF = 0.
  - OP 3, div: restoring division, one bit per cycle; RESULT = {remainder, quotient}.
    - B=0: RESULT = all ones, DIV0 = 1, no iteration.
- Mode 1, logical: OP 0/1/2/3 = A&B, A|B, A^B, ~A; zero-extended.
- Mode 2, compare: OP 0/1/2/3 = (A==B), (A>B), (A<B), max(A,B); unsigned; zero-extended.
- Mode 3: RESULT = 0, flags 0.
- OVF and DIV0 are 0 for every operation not listed above.
- FSM:
  - IDLE: on START, go to FINISH for single-cycle ops; go to RUN for mul/div with B≠0.
  - RUN: counter counts down W..1; when it reaches 1, go to FINISH.
  - FINISH: load RESULT and flags, pulse DONE, return to IDLE.
- BUSY = (state ≠ IDLE).

## Timing
- Reset values: MODE=0, RESULT=0, OVF=0, DIV0=0, BUSY=0, DONE=0, state IDLE, synchronizer flops 1 (released).
- Single-cycle ops: START accepted at edge n; BUSY high for n+1; DONE and RESULT valid at n+1; BUSY low at n+2.
- Mul/div: START at edge n; BUSY high for W+1 cycles; DONE at n+W+1.
- Back-to-back: START asserted in the cycle after DONE is accepted.
- Key latency: MODE changes 3 cycles after the KEY_N falling edge (2-flop sync plus edge register). A held key produces one step only.
- RST_N low mid-operation: at that edge, all outputs return to reset values, no DONE is issued, and RESULT returns to 0.
- RESULT and the flags change only in FINISH or on reset. Between DONE pulses they are stable regardless of A, B, OP and MODE.

## Structure
- Package calc_pkg holds:
  - mode encodings: MODE_ARITH, MODE_LOGIC, MODE_CMP, MODE_RSVD;
  - op encodings per mode;
  - state enum: IDLE, RUN, FINISH.
- Sub-module calc_muldiv holds:
  - the iterative shift-add multiplier and restoring divider, with a shared W-cycle counter;
  - a start/done handshake toward calc_engine;
  - parameter W.
- Key synchronizer and edge detect stay inline in calc_engine.

## Test plan
- Reset, then KEY_N[0] pressed twice, then KEY_N[1] pressed three times:
  - MODE sequence 0→1→2→1→0→3;
  - each step appears 3 cycles after its press;
  - simultaneous press of both keys leaves MODE unchanged.
- W=4, MODE 0:
  - OP 0, A=F, B=1 → RESULT=0x10, OVF=1, DONE 1 cycle after START.
  - OP 1, A=3, B=5 → RESULT=0xFE, OVF=1.
- W=4, MODE 0, OP 2, A=F, B=F → RESULT=0xE1; BUSY high for 5 cycles; DONE at START+5; START pulses while BUSY are ignored.
- W=4, MODE 0, OP 3:
  - A=D, B=3 → RESULT=0x14 (rem 1, quot 4), DIV0=0.
  - A=7, B=0 → RESULT=0xFF, DIV0=1, DONE at START+1.
- W=4, MODE 2, OP 3, A=6, B=9 → RESULT=0x09. Changing A, B, OP and MODE afterwards leaves RESULT unchanged until the next DONE.
- W=8, MODE 0, OP 2 in flight, RST_N low at cycle 4 → no DONE; RESULT=0, BUSY=0, MODE=0 on the next cycle.
